// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM state type for the binary-to-BCD converter
package bcd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX = 9999;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction, add 3 when the digit is 5 or more
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble converter, BCD_SATURATE_EN selects 9999 vs blank on overflow
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
`ifdef BCD_SATURATE_EN
    localparam logic [BCD_W-1:0] OVF_CODE = 16'h9999;
`else
    localparam logic [BCD_W-1:0] OVF_CODE = {NUM_DIGITS{BLANK_DIGIT}};
`endif

    state_t                   state;
    state_t                   next_state;
    logic [BIN_W-1:0]         shift_reg;
    logic [BCD_W-1:0]         scratch;
    logic [BCD_W-1:0]         adj;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_cap;
    logic                     over;
    logic                     last_shift;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit (scratch[4*g +: 4]),
            .adj   (adj[4*g +: 4])
        );
    end

    assign shifted    = {adj, shift_reg} << 1;
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // Narrower inputs can never exceed 9999, so the compare is dropped entirely.
    if (BIN_W >= 14) begin : g_ovf_cmp
        assign over = (32'(bin_in) > 32'(BCD_MAX));
    end else begin : g_no_ovf
        assign over = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_shift) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result registers load on the final shift edge so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_cap   <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        cnt       <= '0;
                        ovf_cap   <= over;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= shifted;
                    cnt <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bcd_out <= ovf_cap ? OVF_CODE : shifted[BIN_W +: BCD_W];
                        ovf     <= ovf_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb/tb_bin_to_bcd.sv - scoreboard bench for bin_to_bcd with directed vectors
module tb_bin_to_bcd;

    localparam int BIN_W = 14;
`ifdef BCD_SATURATE_EN
    localparam logic [15:0] OVF_BCD = 16'h9999;
`else
    localparam logic [15:0] OVF_BCD = 16'hFFFF;
`endif

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    bin_to_bcd #(.BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 (bcd_out=%h) expected no pending conversion", bcd_out);
            end else begin
                mon_e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("latency_edges", 32'(cyc - mon_e.acc), 32'(BIN_W));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [BIN_W-1:0] v, input logic [15:0] eb, input logic eo);
        exp_t x;
        bin_in = v;
        start  = 1'b1;
        x.bcd  = eb;
        x.ovf  = eo;
        x.acc  = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'h2AAA;
    endtask

    task automatic convert(input logic [BIN_W-1:0] v, input logic [15:0] eb, input logic eo);
        wait_idle("convert");
        issue(v, eb, eo);
        wait_drain();
    endtask

    initial begin
        int base;
        int low;
        int n;
        exp_t x;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        convert(14'd0,     16'h0000, 1'b0);
        convert(14'd1234,  16'h1234, 1'b0);
        convert(14'd9999,  16'h9999, 1'b0);
        convert(14'd10000, OVF_BCD,  1'b1);
        convert(14'd5,     16'h0005, 1'b0);
        convert(14'd10,    16'h0010, 1'b0);
        convert(14'd8191,  16'h8191, 1'b0);

        // Starts while busy, including one coincident with done, must be dropped.
        base = done_cnt;
        wait_idle("ignore");
        issue(14'd42, 16'h0042, 1'b0);
        repeat (3) @(negedge clk);
        bin_in = 14'd77;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_42", 32'(done), 32'd1);
        bin_in = 14'd99;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_bcd_42", 32'(bcd_out), 32'h0042);
        check("hold_ovf_42", 32'(ovf), 32'd0);
        check("idle_after_42", 32'(busy), 32'd0);
        check("single_done_42", 32'(done_cnt - base), 32'd1);
        wait_drain();

        // Reset mid-conversion aborts without a done pulse.
        base = done_cnt;
        wait_idle("abort");
        bin_in = 14'd555;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (6) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        convert(14'd8, 16'h0008, 1'b0);

        // Start held high: one acceptance per BIN_W+2 cycles, one idle cycle each period.
        base   = done_cnt;
        low    = 0;
        bin_in = 14'd16383;
        start  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (busy === 1'b0) begin
                low++;
                x.bcd = OVF_BCD;
                x.ovf = 1'b1;
                x.acc = cyc + 1;
                sb.push_back(x);
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();
        check("continuous_idle_cycles", 32'(low), 32'd4);
        check("continuous_done_count", 32'(done_cnt - base), 32'd4);
        check("continuous_final_ovf", 32'(ovf), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter BIN_W SHALL be: BIN_W, default 14, binary input width (legal range 4..14).
REQ-002 Port clk SHALL be: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  synchronous, active-high reset.
REQ-004 Port start SHALL be: start  input  1  request to convert bin_in; sampled on clk.
REQ-005 Port bin_in SHALL be: bin_in  input  BIN_W  unsigned binary value; sampled on the accepting cycle only.
REQ-006 Port busy SHALL be: busy  output  1  high while a conversion is in progress.
REQ-007 Port done SHALL be: done  output  1  one-cycle pulse when bcd_out is updated.
REQ-008 Port bcd_out SHALL be: bcd_out  output  16  four packed BCD digits, thousands in [15:12], units in [3:0]; feeds the 7-segment display stage directly.
REQ-009 Port ovf SHALL be: ovf  output  1  high when the last accepted value exceeded 9999; updated with done.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 In IDLE, start=1 SHALL capture bin_in, clear the 16-bit BCD scratch register and the iteration counter, and move to SHIFT on the next edge.
REQ-012 In SHIFT, each cycle SHALL apply the double-dabble step: every scratch digit >=5 gets +3, then {scratch,shift reg} shifts left by one bit.
REQ-013 SHIFT SHALL last exactly BIN_W cycles, then move to DONE.
REQ-014 In DONE, bcd_out and ovf SHALL load the final result, done SHALL be 1 for that single cycle, and the FSM SHALL return to IDLE.
REQ-015 Latency SHALL be fixed: start accepted at edge N -> done=1 during cycle N+BIN_W+1, independent of value.
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-017 start while busy=1 SHALL be ignored without queuing, including start coincident with done.
REQ-018 A start SHALL be accepted in the first IDLE cycle after DONE (back-to-back period BIN_W+2 cycles).
REQ-019 bcd_out and ovf SHALL hold their last values between done pulses; bin_in changes after acceptance SHALL have no effect.
REQ-020 ovf SHALL be set when the captured value is >9999 (compared at capture), else cleared at done.
REQ-021 For BIN_W<14, ovf SHALL be constant 0 and the compare may be optimised away.
REQ-022 Every bcd_out digit SHALL be 0..9 whenever ovf=0.

Reset
REQ-023 rst=1 SHALL force, on the next edge: state IDLE, busy=0, done=0, bcd_out=16'h0000, ovf=0, counter and scratch cleared.
REQ-024 rst asserted mid-conversion SHALL abort it with no done pulse; rst SHALL take priority over start.

Configuration
REQ-025 Macro BCD_SATURATE_EN defined: an overflowing conversion SHALL set bcd_out=16'h9999 with ovf=1.
REQ-026 Macro BCD_SATURATE_EN undefined: an overflowing conversion SHALL set bcd_out=16'hFFFF (non-decimal codes, which the display stage blanks) with ovf=1.
REQ-027 Timing and handshake SHALL be identical with and without the macro.

Structure
REQ-028 Package bcd_pkg SHALL hold NUM_DIGITS=4, BCD_MAX=9999, BLANK_DIGIT=4'hF, and the FSM state enum (IDLE, SHIFT, DONE).
REQ-029 Sub-module bcd_digit_adj (4-bit combinational add-3-if->=5) SHALL be instantiated once per digit.
REQ-030 The iteration counter SHALL be $clog2(BIN_W+1) bits wide.

Verification
REQ-031 bin_in=0, start 1 cycle -> done at cycle 15, bcd_out=16'h0000, ovf=0.
REQ-032 bin_in=1234 -> bcd_out=16'h1234; bin_in=9999 -> 16'h9999, ovf=0.
REQ-033 bin_in=10000 -> ovf=1; bcd_out=16'h9999 with BCD_SATURATE_EN, 16'hFFFF without.
REQ-034 start=1 with bin_in=42, then start=1 with bin_in=77 at cycle 5 -> single done, bcd_out=16'h0042.
REQ-035 rst pulsed at cycle 7 of a conversion of 555 -> no done, bcd_out=16'h0000; next start with 8 -> 16'h0008 at latency 15.
REQ-036 Start held high continuously with bin_in=16383 -> done every 16 cycles, ovf=1 each time, busy low exactly 1 cycle per period.
